// File: rtl/pea_shot_ctrl.sv
// rtl/pea_shot_ctrl.sv - single-pea object controller: spawn, flight, burst animation, cooldown
module pea_shot_ctrl #(
    parameter int SPEED        = 4,
    parameter int SPAWN_DX     = 34,
    parameter int SPAWN_DY     = 5,
    parameter int X_LIMIT      = 624,
    parameter int Y_LIMIT      = 464,
    parameter int ANIM_DIV     = 4,
    parameter int BURST_FRAMES = 3,
    parameter int COOL_FRAMES  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick_i,
    input  logic       game_run_i,
    input  logic       fire_i,
    input  logic       hit_i,
    input  logic [9:0] bird_x_i,
    input  logic [9:0] bird_y_i,
    output logic       peas_valid_o,
    output logic [9:0] peas_x_o,
    output logic [9:0] peas_y_o,
    output logic [2:0] peas_type_o,
    output logic [7:0] hit_count_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_FLY, S_BURST, S_COOL} state_t;

    localparam logic [10:0] X_LIM11    = 11'(X_LIMIT);
    localparam logic [10:0] Y_LIM11    = 11'(Y_LIMIT);
    localparam logic [10:0] SPEED11    = 11'(SPEED);
    localparam logic [10:0] DX11       = 11'(SPAWN_DX);
    localparam logic [10:0] DY11       = 11'(SPAWN_DY);
    localparam logic [7:0]  ANIM_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [7:0]  BURST_LAST = 8'(BURST_FRAMES - 1);
    localparam logic [7:0]  COOL_LAST  = 8'(COOL_FRAMES - 1);

    state_t      state_q;
    logic        valid_q, busy_q, fire_q, fire_pend_q, hit_pend_q;
    logic [9:0]  x_q, y_q;
    logic [2:0]  type_q;
    logic [7:0]  hit_cnt_q, anim_q, burst_q, cool_q;

    logic        fire_rise_d, hit_now_d;
    logic [10:0] spawn_x_sum_d, spawn_y_sum_d, fly_x_sum_d;
    logic [9:0]  spawn_x_d, spawn_y_d;

    // Sums are kept 11 bits wide so a bird near the right edge clamps instead of wrapping.
    assign fire_rise_d   = fire_i & ~fire_q;
    assign hit_now_d     = hit_pend_q | hit_i;
    assign spawn_x_sum_d = {1'b0, bird_x_i} + DX11;
    assign spawn_y_sum_d = {1'b0, bird_y_i} + DY11;
    assign fly_x_sum_d   = {1'b0, x_q} + SPEED11;
    assign spawn_x_d     = (spawn_x_sum_d > X_LIM11) ? X_LIM11[9:0] : spawn_x_sum_d[9:0];
    assign spawn_y_d     = (spawn_y_sum_d > Y_LIM11) ? Y_LIM11[9:0] : spawn_y_sum_d[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fire_q      <= 1'b0;
            fire_pend_q <= 1'b0;
            hit_pend_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            type_q      <= '0;
            hit_cnt_q   <= '0;
            anim_q      <= '0;
            burst_q     <= '0;
            cool_q      <= '0;
        end else begin
            fire_q <= fire_i;
            if (!game_run_i) begin
                state_q     <= S_IDLE;
                valid_q     <= 1'b0;
                busy_q      <= 1'b0;
                fire_pend_q <= 1'b0;
                hit_pend_q  <= 1'b0;
                anim_q      <= '0;
                burst_q     <= '0;
                cool_q      <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Only a rise already registered before the tick spawns on that tick.
                        if (frame_tick_i && fire_pend_q) begin
                            state_q     <= S_FLY;
                            busy_q      <= 1'b1;
                            valid_q     <= 1'b1;
                            x_q         <= spawn_x_d;
                            y_q         <= spawn_y_d;
                            type_q      <= 3'd0;
                            anim_q      <= '0;
                            fire_pend_q <= 1'b0;
                            hit_pend_q  <= 1'b0;
                        end else if (fire_rise_d) begin
                            fire_pend_q <= 1'b1;
                        end
                    end
                    S_FLY: begin
                        if (frame_tick_i && hit_now_d) begin
                            state_q    <= S_BURST;
                            type_q     <= 3'd4;
                            burst_q    <= '0;
                            hit_pend_q <= 1'b0;
                            if (hit_cnt_q != 8'hff) hit_cnt_q <= hit_cnt_q + 8'd1;
                        end else if (frame_tick_i) begin
                            if (fly_x_sum_d > X_LIM11) begin
                                state_q <= S_COOL;
                                valid_q <= 1'b0;
                                cool_q  <= '0;
                            end else begin
                                x_q <= fly_x_sum_d[9:0];
                                if (anim_q == ANIM_LAST) begin
                                    anim_q <= '0;
                                    type_q <= {1'b0, type_q[1:0] + 2'd1};
                                end else begin
                                    anim_q <= anim_q + 8'd1;
                                end
                            end
                        end else if (hit_i) begin
                            hit_pend_q <= 1'b1;
                        end
                    end
                    S_BURST: begin
                        if (frame_tick_i) begin
                            if (burst_q == BURST_LAST) begin
                                burst_q <= '0;
                                if (type_q != 3'd7) begin
                                    type_q <= type_q + 3'd1;
                                end else begin
                                    state_q <= S_COOL;
                                    valid_q <= 1'b0;
                                    cool_q  <= '0;
                                end
                            end else begin
                                burst_q <= burst_q + 8'd1;
                            end
                        end
                    end
                    S_COOL: begin
                        if (frame_tick_i) begin
                            if (cool_q == COOL_LAST) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                cool_q  <= '0;
                            end else begin
                                cool_q <= cool_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign peas_valid_o = valid_q;
    assign peas_x_o     = x_q;
    assign peas_y_o     = y_q;
    assign peas_type_o  = type_q;
    assign hit_count_o  = hit_cnt_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_pea_shot_ctrl.sv
// tb/tb_pea_shot_ctrl.sv - self-checking bench for pea_shot_ctrl
module tb_pea_shot_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, game_run = 1'b0, fire = 1'b0, hit = 1'b0;
    logic [9:0] bird_x = '0, bird_y = '0;
    logic       peas_valid, busy;
    logic [9:0] peas_x, peas_y;
    logic [2:0] peas_type;
    logic [7:0] hit_count;

    int checks = 0;
    int failures = 0;
    logic [9:0] bx = '0, by = '0;

    pea_shot_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .frame_tick_i(frame_tick), .game_run_i(game_run), .fire_i(fire), .hit_i(hit),
        .bird_x_i(bird_x), .bird_y_i(bird_y),
        .peas_valid_o(peas_valid), .peas_x_o(peas_x), .peas_y_o(peas_y),
        .peas_type_o(peas_type), .hit_count_o(hit_count), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 fly, 2 burst, 3 cool; n counts ticks spent in the phase.
    int m_phase, m_n, m_sx, m_x, m_y, m_type, m_valid, m_hits, m_pfire, m_phit, m_prev;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_sx = 0; m_x = 0; m_y = 0; m_type = 0;
        m_valid = 0; m_hits = 0; m_pfire = 0; m_phit = 0; m_prev = 0;
    endtask

    task automatic model_step(input int t, input int r, input int f, input int h,
                              input int x0, input int y0);
        int rise;
        rise = f && !m_prev;
        m_prev = f;
        if (!r) begin
            m_phase = 0; m_valid = 0; m_pfire = 0; m_phit = 0; m_n = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (t && m_pfire) begin
                    m_phase = 1; m_n = 0; m_sx = imin(x0 + 34, 624);
                    m_x = m_sx; m_y = imin(y0 + 5, 464); m_type = 0; m_valid = 1;
                    m_pfire = 0; m_phit = 0;
                end else if (rise) m_pfire = 1;
            end
            1: begin
                if (h) m_phit = 1;
                if (t) begin
                    if (m_phit) begin
                        m_phase = 2; m_n = 0; m_type = 4; m_phit = 0;
                        m_hits = imin(m_hits + 1, 255);
                    end else if (m_x + 4 > 624) begin
                        m_phase = 3; m_n = 0; m_valid = 0;
                    end else begin
                        m_n++;
                        m_x = m_sx + 4 * m_n;
                        m_type = (m_n / 4) % 4;
                    end
                end
            end
            2: if (t) begin
                m_n++;
                if (m_n == 12) begin m_phase = 3; m_n = 0; m_valid = 0; end
                else m_type = 4 + m_n / 3;
            end
            default: if (t) begin
                m_n++;
                if (m_n == 10) begin m_phase = 0; m_n = 0; end
            end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        checks++;
        if (peas_valid != m_valid[0] || peas_x != m_x[9:0] || peas_y != m_y[9:0] ||
            peas_type != m_type[2:0] || hit_count != m_hits[7:0] || busy != (m_phase != 0)) begin
            failures++;
            $display("FAIL model_cmp @%0t: got v=%0d x=%0d y=%0d t=%0d hc=%0d b=%0d expected v=%0d x=%0d y=%0d t=%0d hc=%0d b=%0d",
                     $time, peas_valid, peas_x, peas_y, peas_type, hit_count, busy,
                     m_valid, m_x, m_y, m_type, m_hits, (m_phase != 0));
        end
    endtask

    task automatic cyc(input logic t, input logic r, input logic f, input logic h);
        frame_tick = t; game_run = r; fire = f; hit = h; bird_x = bx; bird_y = by;
        @(posedge clk);
        model_step(int'(t), int'(r), int'(f), int'(h), int'(bx), int'(by));
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic tick, run, fire, hit;
        int   ev, ex, ey, et, eb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0,   0,   0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 134, 205, 0, 1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 138, 205, 0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 142, 205, 0, 1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 146, 205, 0, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 150, 205, 1, 1};

        model_reset();
        #2;
        chk("reset_valid", int'(peas_valid), 0);
        chk("reset_x", int'(peas_x), 0);
        chk("reset_y", int'(peas_y), 0);
        chk("reset_type", int'(peas_type), 0);
        chk("reset_hits", int'(hit_count), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        bx = 10'd100; by = 10'd200;
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].tick, tbl[i].run, tbl[i].fire, tbl[i].hit);
            chk("tbl_valid", int'(peas_valid), tbl[i].ev);
            chk("tbl_x", int'(peas_x), tbl[i].ex);
            chk("tbl_y", int'(peas_y), tbl[i].ey);
            chk("tbl_type", int'(peas_type), tbl[i].et);
            chk("tbl_busy", int'(busy), tbl[i].eb);
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("spin_wrap_type", int'(peas_type), 0);
        chk("spin_wrap_x", int'(peas_x), 198);

        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(peas_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Right-edge clamp, immediate overrun, and cooldown length.
        bx = 10'd600; by = 10'd470;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clamp_x", int'(peas_x), 624);
        chk("clamp_y", int'(peas_y), 464);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("overrun_valid", int'(peas_valid), 0);
        chk("overrun_busy", int'(busy), 1);
        for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b1, (i == 3), 1'b0);
        chk("cool_9_busy", int'(busy), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("cool_10_busy", int'(busy), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("cool_fire_dropped", int'(peas_valid), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_cool_spawn", int'(peas_valid), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Hit mid-flight, burst sequence, second hit ignored.
        bx = 10'd166; by = 10'd50;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("hit_spawn_x", int'(peas_x), 200);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("burst_type4", int'(peas_type), 4);
        chk("burst_x", int'(peas_x), 200);
        chk("burst_hits", int'(hit_count), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 3) chk("burst_type5", int'(peas_type), 5);
            if (k == 6) chk("burst_type6", int'(peas_type), 6);
            if (k == 9) chk("burst_type7", int'(peas_type), 7);
            if (k == 12) chk("burst_end_valid", int'(peas_valid), 0);
        end
        chk("burst_second_hit", int'(hit_count), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Hit and overrun on the same tick: hit wins; then abort mid-burst.
        bx = 10'd600; by = 10'd100;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("hit_beats_edge_type", int'(peas_type), 4);
        chk("hit_beats_edge_valid", int'(peas_valid), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_valid", int'(peas_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_hits", int'(hit_count), 2);

        bx = 10'd100; by = 10'd200;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("hits_saturate", int'(hit_count), 255);

        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("coincident_fire_no_spawn", int'(peas_valid), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("coincident_fire_spawn", int'(peas_valid), 1);

        // Randomized run against the model.
        begin
            logic f_lvl;
            f_lvl = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 3) == 0) f_lvl = ~f_lvl;
                bx = 10'($urandom_range(0, 1023));
                by = 10'($urandom_range(0, 1023));
                cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0),
                    f_lvl, ($urandom_range(0, 15) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
